// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access pipeline stage.
package mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    localparam int WAIT_LIMIT_DEF = 15;

endpackage

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues one bus transaction per load/store,
// stalls execute while waiting, and registers the writeback result.
//
// state | meaning
// IDLE  | accepting ex_mem_* each edge; ALU results pass straight to writeback
// WAIT  | bus strobe held, execute stalled until mem_ready or timeout
module mem_access
    import mem_pkg::*;
#(
    parameter int WAIT_LIMIT = WAIT_LIMIT_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_mem_readmem,
    input  logic        ex_mem_writemem,
    input  logic [31:0] ex_mem_regb,
    input  logic        ex_mem_selwsource,
    input  logic [4:0]  ex_mem_regdest,
    input  logic        ex_mem_writereg,
    input  logic [31:0] ex_mem_wbvalue,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_ex_stall,
    output logic        mem_wb_writereg,
    output logic [4:0]  mem_wb_regdest,
    output logic [31:0] mem_wb_wbvalue,
    output logic        mem_fault
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    mem_state_t       state, state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [4:0]       cap_regdest;
    logic             cap_writereg;
    logic             cap_selw;

    logic mem_op, aligned;
    logic start, misalign, done, timeout;

    assign mem_op       = ex_mem_readmem | ex_mem_writemem;
    assign aligned      = (ex_mem_wbvalue[1:0] == 2'b00);
    assign mem_ex_stall = (state == WAIT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        misalign   = 1'b0;
        done       = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op && aligned) begin
                    start      = 1'b1;
                    state_next = WAIT;
                end else if (mem_op) begin
                    misalign = 1'b1;
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else if (wait_cnt == CNT_W'(WAIT_LIMIT - 1)) begin
                    // this cycle would bring the count up to WAIT_LIMIT
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt        <= '0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
            mem_rd          <= 1'b0;
            mem_wr          <= 1'b0;
            mem_wb_writereg <= 1'b0;
            mem_wb_regdest  <= '0;
            mem_wb_wbvalue  <= '0;
            mem_fault       <= 1'b0;
            cap_regdest     <= '0;
            cap_writereg    <= 1'b0;
            cap_selw        <= 1'b0;
        end else begin
            mem_fault <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    wait_cnt        <= '0;
                    mem_addr        <= ex_mem_wbvalue;
                    mem_wdata       <= ex_mem_regb;
                    mem_wr          <= ex_mem_writemem;
                    mem_rd          <= ~ex_mem_writemem;
                    cap_regdest     <= ex_mem_regdest;
                    cap_writereg    <= ex_mem_writereg;
                    cap_selw        <= ex_mem_selwsource;
                    mem_wb_writereg <= 1'b0;
                end else if (misalign) begin
                    mem_fault       <= 1'b1;
                    mem_wb_writereg <= 1'b0;
                end else begin
                    mem_wb_writereg <= ex_mem_writereg;
                    mem_wb_regdest  <= ex_mem_regdest;
                    mem_wb_wbvalue  <= ex_mem_wbvalue;
                end
            end else if (done) begin
                mem_rd <= 1'b0;
                mem_wr <= 1'b0;
                if (mem_rd) begin
                    mem_wb_writereg <= cap_writereg;
                    mem_wb_regdest  <= cap_regdest;
                    mem_wb_wbvalue  <= cap_selw ? mem_rdata : mem_addr;
                end else begin
                    mem_wb_writereg <= 1'b0;
                end
            end else if (timeout) begin
                mem_rd          <= 1'b0;
                mem_wr          <= 1'b0;
                mem_fault       <= 1'b1;
                mem_wb_writereg <= 1'b0;
            end else begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus queues expected bus, stall,
// writeback and fault events; a negedge monitor pops and compares them.
module tb_mem_access;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_mem_readmem, ex_mem_writemem, ex_mem_selwsource, ex_mem_writereg;
    logic [31:0] ex_mem_regb, ex_mem_wbvalue;
    logic [4:0]  ex_mem_regdest;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rd, mem_wr, mem_ready, mem_ex_stall;
    logic        mem_wb_writereg, mem_fault;
    logic [4:0]  mem_wb_regdest;
    logic [31:0] mem_wb_wbvalue;

    mem_access #(.WAIT_LIMIT(15)) dut (
        .clock(clock), .reset(reset),
        .ex_mem_readmem(ex_mem_readmem), .ex_mem_writemem(ex_mem_writemem),
        .ex_mem_regb(ex_mem_regb), .ex_mem_selwsource(ex_mem_selwsource),
        .ex_mem_regdest(ex_mem_regdest), .ex_mem_writereg(ex_mem_writereg),
        .ex_mem_wbvalue(ex_mem_wbvalue),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_ex_stall(mem_ex_stall),
        .mem_wb_writereg(mem_wb_writereg), .mem_wb_regdest(mem_wb_regdest),
        .mem_wb_wbvalue(mem_wb_wbvalue), .mem_fault(mem_fault)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          len;
    } bus_t;

    typedef struct {
        logic [4:0]  regdest;
        logic [31:0] value;
    } wb_t;

    bus_t q_bus[$];
    wb_t  q_wb[$];
    int   q_stall[$];
    int   q_fault[$];

    int n_cmp = 0;
    int n_bad = 0;
    int strobe_len = 0;
    int stall_len = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %h with nothing expected", name, act);
    endtask

    // monitor
    always @(negedge clock) begin
        if (mem_rd || mem_wr) begin
            strobe_len++;
            if (q_bus.size() == 0) begin
                if (strobe_len == 1) fail_evt("bus_unexpected", mem_addr);
            end else begin
                chk("bus_rd", mem_rd, q_bus[0].rd);
                chk("bus_wr", mem_wr, q_bus[0].wr);
                chk("bus_addr", mem_addr, q_bus[0].addr);
                chk("bus_wdata", mem_wdata, q_bus[0].wdata);
            end
        end else if (strobe_len > 0) begin
            if (q_bus.size() != 0) begin
                chk("strobe_len", strobe_len, q_bus[0].len);
                void'(q_bus.pop_front());
            end
            strobe_len = 0;
        end

        if (mem_ex_stall) begin
            stall_len++;
            if (q_stall.size() == 0 && stall_len == 1) fail_evt("stall_unexpected", 1);
        end else if (stall_len > 0) begin
            if (q_stall.size() != 0) chk("stall_len", stall_len, q_stall.pop_front());
            stall_len = 0;
        end

        if (mem_wb_writereg) begin
            if (q_wb.size() == 0) fail_evt("wb_unexpected", mem_wb_wbvalue);
            else begin
                chk("wb_regdest", mem_wb_regdest, q_wb[0].regdest);
                chk("wb_value", mem_wb_wbvalue, q_wb[0].value);
                void'(q_wb.pop_front());
            end
        end

        if (mem_fault) begin
            if (q_fault.size() == 0) fail_evt("fault_unexpected", 1);
            else begin
                chk("fault", mem_fault, 1'b1);
                void'(q_fault.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bubble();
        ex_mem_readmem    = 1'b0;
        ex_mem_writemem   = 1'b0;
        ex_mem_regb       = '0;
        ex_mem_selwsource = 1'b0;
        ex_mem_regdest    = '0;
        ex_mem_writereg   = 1'b0;
        ex_mem_wbvalue    = '0;
    endtask

    task automatic drive(input logic rdm, input logic wrm, input logic [31:0] regb,
                         input logic selw, input logic [4:0] rdst, input logic wreg,
                         input logic [31:0] wbv);
        ex_mem_readmem    = rdm;
        ex_mem_writemem   = wrm;
        ex_mem_regb       = regb;
        ex_mem_selwsource = selw;
        ex_mem_regdest    = rdst;
        ex_mem_writereg   = wreg;
        ex_mem_wbvalue    = wbv;
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = '0;
        bubble();
        repeat (2) tick();

        chk("rst_rd", mem_rd, 1'b0);
        chk("rst_wr", mem_wr, 1'b0);
        chk("rst_stall", mem_ex_stall, 1'b0);
        chk("rst_fault", mem_fault, 1'b0);
        chk("rst_wb_writereg", mem_wb_writereg, 1'b0);
        chk("rst_wb_value", mem_wb_wbvalue, 32'h0);

        // ALU op presented right as reset releases
        @(negedge clock);
        reset = 1'b0;
        drive(0, 0, 32'h0, 0, 5'd5, 1, 32'h0000_0010);
        q_wb.push_back('{5'd5, 32'h10});
        tick();
        bubble();
        repeat (2) tick();

        // load, ready on 3rd WAIT cycle; next ALU op held by execute meanwhile
        drive(1, 0, 32'h0, 1, 5'd3, 1, 32'h0000_0100);
        q_bus.push_back('{1'b1, 1'b0, 32'h100, 32'h0, 3});
        q_stall.push_back(3);
        q_wb.push_back('{5'd3, 32'hDEAD_BEEF});
        q_wb.push_back('{5'd7, 32'h77});
        tick();
        drive(0, 0, 32'h0, 0, 5'd7, 1, 32'h0000_0077);
        tick();
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
        tick();
        bubble();
        repeat (2) tick();

        // store, ready already high in IDLE (ignored there), done on first WAIT cycle
        drive(0, 1, 32'h1234_5678, 0, 5'd2, 1, 32'h0000_0200);
        mem_ready = 1'b1;
        q_bus.push_back('{1'b0, 1'b1, 32'h200, 32'h1234_5678, 1});
        q_stall.push_back(1);
        tick();
        bubble();
        tick();
        mem_ready = 1'b0;
        repeat (2) tick();

        // readmem and writemem together: write wins
        drive(1, 1, 32'hCAFE_F00D, 1, 5'd6, 1, 32'h0000_0204);
        q_bus.push_back('{1'b0, 1'b1, 32'h204, 32'hCAFE_F00D, 2});
        q_stall.push_back(2);
        tick();
        bubble();
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        repeat (2) tick();

        // misaligned load
        drive(1, 0, 32'h0, 1, 5'd8, 1, 32'h0000_0103);
        q_fault.push_back(1);
        tick();
        bubble();
        chk("misalign_stall", mem_ex_stall, 1'b0);
        chk("misalign_rd", mem_rd, 1'b0);
        repeat (2) tick();

        // load with selwsource=0 writes back the address
        drive(1, 0, 32'h0, 0, 5'd9, 1, 32'h0000_0400);
        mem_rdata = 32'h0000_0055;
        q_bus.push_back('{1'b1, 1'b0, 32'h400, 32'h0, 1});
        q_stall.push_back(1);
        q_wb.push_back('{5'd9, 32'h400});
        tick();
        bubble();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
        repeat (2) tick();

        // timeout after 15 WAIT cycles
        drive(1, 0, 32'h0, 1, 5'd10, 1, 32'h0000_0300);
        q_bus.push_back('{1'b1, 1'b0, 32'h300, 32'h0, 15});
        q_stall.push_back(15);
        q_fault.push_back(1);
        tick();
        bubble();
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!mem_ex_stall) break;
        end
        if (mem_ex_stall) fail_evt("timeout_bound", mem_ex_stall);
        repeat (3) tick();

        // reset during the 2nd WAIT cycle
        drive(1, 0, 32'h0, 1, 5'd4, 1, 32'h0000_0500);
        q_bus.push_back('{1'b1, 1'b0, 32'h500, 32'h0, 2});
        q_stall.push_back(2);
        tick();
        bubble();
        tick();
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_wait_rd", mem_rd, 1'b0);
        chk("rst_wait_stall", mem_ex_stall, 1'b0);
        chk("rst_wait_fault", mem_fault, 1'b0);
        tick();
        @(negedge clock);
        reset = 1'b0;
        drive(0, 0, 32'h0, 0, 5'd11, 1, 32'h0000_0ABC);
        q_wb.push_back('{5'd11, 32'hABC});
        tick();
        bubble();
        repeat (3) tick();

        chk("q_bus_empty", q_bus.size(), 0);
        chk("q_stall_empty", q_stall.size(), 0);
        chk("q_wb_empty", q_wb.size(), 0);
        chk("q_fault_empty", q_fault.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
